// File: rtl/hazard_pkg.sv
// Shared types and parameter defaults for the pipeline hazard unit.
package hazard_pkg;
    localparam int REG_W_DEF      = 5;
    localparam int CTRL_W_DEF     = 8;
    localparam int LOAD_STALL_DEF = 1;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LSTALL = 1'b1
    } hz_state_e;
endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side signal bundle of the hazard unit; master drives pipeline state, slave is the unit.
interface hazard_unit_if #(
    parameter int REG_W  = hazard_pkg::REG_W_DEF,
    parameter int CTRL_W = hazard_pkg::CTRL_W_DEF,
    parameter int CNT_W  = hazard_pkg::CNT_W_DEF
);
    logic [REG_W-1:0]  rs1_id, rs2_id;
    logic              rs1_used_id, rs2_used_id;
    logic [REG_W-1:0]  rs1_ex, rs2_ex, rd_ex;
    logic              memread_ex, regwrite_ex, branch_taken_ex;
    logic [REG_W-1:0]  rd_mem, rd_wb;
    logic              regwrite_mem, regwrite_wb, ext_stall;
    logic [CTRL_W-1:0] ctrl_id_in, ctrl_id_out;
    logic              stall_if, stall_id, stall_ex, flush_id, flush_ex;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id,
        output rs1_ex, rs2_ex, rd_ex, memread_ex, regwrite_ex, branch_taken_ex,
        output rd_mem, rd_wb, regwrite_mem, regwrite_wb, ext_stall, ctrl_id_in,
        input  ctrl_id_out, stall_if, stall_id, stall_ex, flush_id, flush_ex,
        input  fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id,
        input  rs1_ex, rs2_ex, rd_ex, memread_ex, regwrite_ex, branch_taken_ex,
        input  rd_mem, rd_wb, regwrite_mem, regwrite_wb, ext_stall, ctrl_id_in,
        output ctrl_id_out, stall_if, stall_id, stall_ex, flush_id, flush_ex,
        output fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// EX operand bypass select; the youngest producer (MEM) wins over WB, x0 is never forwarded.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rd_mem,
    input  logic [REG_W-1:0] rd_wb,
    input  logic             regwrite_mem,
    input  logic             regwrite_wb,
    output fwd_sel_e         sel
);
    always_comb begin
        sel = FWD_RF;
        if (regwrite_mem && (rd_mem != '0) && (rd_mem == rs))
            sel = FWD_MEM;
        else if (regwrite_wb && (rd_wb != '0) && (rd_wb == rs))
            sel = FWD_WB;
    end
endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, branch flush and operand forwarding control for a 5-stage pipeline.
// state  | meaning
// IDLE   | no load stall pending beyond the current cycle
// LSTALL | holding IF/ID and bubbling EX until rem reaches 1
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W      = REG_W_DEF,
    parameter int CTRL_W     = CTRL_W_DEF,
    parameter int LOAD_STALL = LOAD_STALL_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave hz
);
    hz_state_e        state, state_nxt;
    logic [1:0]       rem, rem_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             hit, load_stall;
    fwd_sel_e         sel_a, sel_b;

    assign hit = hz.memread_ex && hz.regwrite_ex && (hz.rd_ex != '0) &&
                 ((hz.rs1_used_id && (hz.rs1_id == hz.rd_ex)) ||
                  (hz.rs2_used_id && (hz.rs2_id == hz.rd_ex)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= 2'd0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            if (load_stall && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // ext_stall freezes everything; a taken branch kills the wrong-path load stall.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        if (hz.ext_stall) begin
            state_nxt = state;
            rem_nxt   = rem;
        end else if (hz.branch_taken_ex) begin
            state_nxt = IDLE;
            rem_nxt   = 2'd0;
        end else if (state == LSTALL) begin
            if (rem == 2'd1) begin
                state_nxt = IDLE;
                rem_nxt   = 2'd0;
            end else begin
                rem_nxt = rem - 2'd1;
            end
        end else if (hit && (LOAD_STALL > 1)) begin
            state_nxt = LSTALL;
            rem_nxt   = 2'(LOAD_STALL - 1);
        end
    end

    always_comb begin
        hz.stall_if = 1'b0;
        hz.stall_id = 1'b0;
        hz.stall_ex = 1'b0;
        hz.flush_id = 1'b0;
        hz.flush_ex = 1'b0;
        load_stall  = 1'b0;
        if (!rst_n) begin
            load_stall = 1'b0;
        end else if (hz.ext_stall) begin
            hz.stall_if = 1'b1;
            hz.stall_id = 1'b1;
            hz.stall_ex = 1'b1;
        end else if (hz.branch_taken_ex) begin
            hz.flush_id = 1'b1;
            hz.flush_ex = 1'b1;
        end else if ((state == LSTALL) || hit) begin
            hz.stall_if = 1'b1;
            hz.stall_id = 1'b1;
            hz.flush_ex = 1'b1;
            load_stall  = 1'b1;
        end
    end

    assign hz.ctrl_id_out = (!rst_n || hz.flush_ex) ? {CTRL_W{1'b0}} : hz.ctrl_id_in;
    assign hz.stall_cnt   = cnt_q;
    assign hz.fwd_a       = rst_n ? sel_a : FWD_RF;
    assign hz.fwd_b       = rst_n ? sel_b : FWD_RF;

    hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .rs           (hz.rs1_ex),
        .rd_mem       (hz.rd_mem),
        .rd_wb        (hz.rd_wb),
        .regwrite_mem (hz.regwrite_mem),
        .regwrite_wb  (hz.regwrite_wb),
        .sel          (sel_a)
    );

    hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .rs           (hz.rs2_ex),
        .rd_mem       (hz.rd_mem),
        .rd_wb        (hz.rd_wb),
        .regwrite_mem (hz.regwrite_mem),
        .regwrite_wb  (hz.regwrite_wb),
        .sel          (sel_b)
    );
endmodule
